// File: rtl/bin_to_bcd_disp.sv
// rtl/bin_to_bcd_disp.sv - sequential double-dabble binary to 4-digit BCD converter with leading-zero blanking
module bin_to_bcd_disp #(
   parameter int BIN_W    = 14,
   parameter int BLANK_LZ = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [4:0]       bcd0,
   output logic [4:0]       bcd1,
   output logic [4:0]       bcd2,
   output logic [4:0]       bcd3
);

   localparam int               CNT_W   = $clog2(BIN_W + 1);
   localparam logic [4:0]       BLANK   = 5'h1F;
   localparam logic [BIN_W-1:0] SAT_MAX = BIN_W'(9999);

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [BIN_W-1:0] r_sreg;
   logic [15:0]      r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic             r_ovf;
   logic [4:0]       r_bcd0, r_bcd1, r_bcd2, r_bcd3;

   logic [15:0]      w_adj;
   logic             w_ovf;
   logic [BIN_W-1:0] w_sat;
   logic             w_last;
   logic             w_b3, w_b2, w_b1;

   // Values above four digits saturate so the display shows 9999 and flags ovf.
   assign w_ovf  = (bin > SAT_MAX);
   assign w_sat  = w_ovf ? SAT_MAX : bin;
   assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

   // Leading-zero blanking cascades from the thousands digit down; ones is never blank.
   assign w_b3 = (BLANK_LZ != 0) && (r_acc[15:12] == 4'd0);
   assign w_b2 = w_b3 && (r_acc[11:8] == 4'd0);
   assign w_b1 = w_b2 && (r_acc[7:4] == 4'd0);

   // busy covers the whole conversion including the done cycle.
   assign busy = (r_state != IDLE) || r_done;
   assign done = r_done;
   assign ovf  = r_ovf;
   assign bcd0 = r_bcd0;
   assign bcd1 = r_bcd1;
   assign bcd2 = r_bcd2;
   assign bcd3 = r_bcd3;

   // Add-3 correction on every nibble that would overflow past 9 when doubled.
   always_comb begin
      w_adj = r_acc;
      for (int i = 0; i < 4; i++) begin
         if (r_acc[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: start is only honoured in IDLE, never queued.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = SHIFT;
         SHIFT:   if (w_last) w_next = LOAD;
         LOAD:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath: load, shift-add-3 once per clock, then publish digits together with done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sreg <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
         r_ovf  <= 1'b0;
         r_bcd3 <= BLANK;
         r_bcd2 <= BLANK;
         r_bcd1 <= BLANK;
         r_bcd0 <= 5'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sreg <= w_sat;
                  r_ovf  <= w_ovf;
                  r_acc  <= '0;
                  r_cnt  <= '0;
               end
            end
            SHIFT: begin
               r_acc  <= {w_adj[14:0], r_sreg[BIN_W-1]};
               r_sreg <= {r_sreg[BIN_W-2:0], 1'b0};
               r_cnt  <= r_cnt + CNT_W'(1);
            end
            LOAD: begin
               r_bcd3 <= w_b3 ? BLANK : {1'b0, r_acc[15:12]};
               r_bcd2 <= w_b2 ? BLANK : {1'b0, r_acc[11:8]};
               r_bcd1 <= w_b1 ? BLANK : {1'b0, r_acc[7:4]};
               r_bcd0 <= {1'b0, r_acc[3:0]};
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_disp.sv
// tb/tb_bin_to_bcd_disp.sv - scoreboard bench for bin_to_bcd_disp, blanking and non-blanking instances
module tb_bin_to_bcd_disp;

   localparam int BIN_W = 14;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [BIN_W-1:0] bin = '0;

   logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
   logic [4:0] a3, a2, a1, a0, b3, b2, b1, b0;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   logic [20:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
   int          stamp[$];

   bin_to_bcd_disp #(.BIN_W(BIN_W), .BLANK_LZ(1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .bin(bin),
      .busy(busy_a), .done(done_a), .ovf(ovf_a),
      .bcd0(a0), .bcd1(a1), .bcd2(a2), .bcd3(a3)
   );

   bin_to_bcd_disp #(.BIN_W(BIN_W), .BLANK_LZ(0)) dut_b (
      .clk(clk), .reset(reset), .start(start), .bin(bin),
      .busy(busy_b), .done(done_b), .ovf(ovf_b),
      .bcd0(b0), .bcd1(b1), .bcd2(b2), .bcd3(b3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every published result with the cycle it appeared in.
   always @(negedge clk) begin
      if (done_a) begin
         got_a.push_back({ovf_a, a3, a2, a1, a0});
         stamp.push_back(cyc);
      end
      if (done_b) got_b.push_back({ovf_b, b3, b2, b1, b0});
   end

   function automatic logic [20:0] exp_word(input int v, input bit blank);
      int s, d3, d2, d1, d0;
      bit z3, z2, z1;
      s  = (v > 9999) ? 9999 : v;
      d3 = s / 1000;
      d2 = (s / 100) % 10;
      d1 = (s / 10) % 10;
      d0 = s % 10;
      z3 = blank && (d3 == 0);
      z2 = z3 && (d2 == 0);
      z1 = z2 && (d1 == 0);
      return {(v > 9999), (z3 ? 5'h1F : 5'(d3)), (z2 ? 5'h1F : 5'(d2)),
              (z1 ? 5'h1F : 5'(d1)), 5'(d0)};
   endfunction

   task automatic issue(input int v, input bit push, output int k);
      @(posedge clk);
      #1;
      start = 1'b1;
      bin   = BIN_W'(v);
      if (push) begin
         exp_a.push_back(exp_word(v, 1'b1));
         exp_b.push_back(exp_word(v, 1'b0));
      end
      @(posedge clk);
      #1;
      k     = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         #1;
         ok = (got_a.size() > 0) && (got_b.size() > 0);
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      vectors++;
      if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
      vectors++;
      if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done_a); end
      vectors++;
      if (ovf_a !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
      vectors++;
      if ({a3, a2, a1, a0} !== {5'h1F, 5'h1F, 5'h1F, 5'h00}) begin
         miscompares++;
         $display("FAIL reset_digits_a got=%h %h %h %h exp=1f 1f 1f 0", a3, a2, a1, a0);
      end
      vectors++;
      if ({busy_b, done_b, ovf_b, b3, b2, b1, b0} !== {3'b000, 5'h1F, 5'h1F, 5'h1F, 5'h00}) begin
         miscompares++;
         $display("FAIL reset_b got=%b%b%b %h %h %h %h", busy_b, done_b, ovf_b, b3, b2, b1, b0);
      end
   endtask

   task automatic test_basic;
      int k, s, busy_low, early_done;
      bit ok;
      logic [20:0] ga, gb, ea, eb;
      busy_low   = 0;
      early_done = 0;
      issue(1234, 1'b1, k);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (busy_a !== 1'b1) busy_low++;
         if (i < 16 && done_a !== 1'b0) early_done++;
      end
      vectors++;
      if (busy_low != 0) begin miscompares++; $display("FAIL basic_busy low_cycles=%0d exp=0", busy_low); end
      vectors++;
      if (early_done != 0 || done_a !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_done early=%0d done_at_k15=%b exp=0/1", early_done, done_a);
      end
      @(negedge clk);
      vectors++;
      if ({busy_a, done_a} !== 2'b00) begin
         miscompares++;
         $display("FAIL basic_after got busy/done=%b%b exp=00", busy_a, done_a);
      end
      wait_done(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL basic_result timeout");
      end else begin
         ga = got_a.pop_front(); gb = got_b.pop_front(); s = stamp.pop_front();
         ea = exp_a.pop_front(); eb = exp_b.pop_front();
         if ({ga, gb} !== {ea, eb}) begin
            miscompares++;
            $display("FAIL basic_result got=%h/%h exp=%h/%h", ga, gb, ea, eb);
         end
         vectors++;
         if (s != k + 15) begin miscompares++; $display("FAIL basic_latency got=%0d exp=%0d", s, k + 15); end
      end
   endtask

   task automatic run_table(input string tag, input int vals[4], input int n);
      int k, s;
      bit ok;
      logic [20:0] ga, gb, ea, eb;
      for (int j = 0; j < n; j++) begin
         issue(vals[j], 1'b1, k);
         wait_done(ok);
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("FAIL %s_%0d timeout", tag, vals[j]);
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
         end else begin
            ga = got_a.pop_front(); gb = got_b.pop_front(); s = stamp.pop_front();
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            if ({ga, gb} !== {ea, eb}) begin
               miscompares++;
               $display("FAIL %s_%0d got=%h/%h exp=%h/%h", tag, vals[j], ga, gb, ea, eb);
            end
         end
      end
   endtask

   task automatic test_blanking;
      int vals[4] = '{205, 0, 30, 1000};
      run_table("blank", vals, 4);
   endtask

   task automatic test_saturate;
      int vals[4] = '{9999, 10000, 16383, 7};
      run_table("sat", vals, 4);
   endtask

   task automatic test_ignore_busy;
      int k, s;
      bit ok;
      logic [20:0] ga, gb, ea, eb;
      issue(4321, 1'b1, k);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      bin   = BIN_W'(1111);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL ignore_result timeout");
      end else begin
         ga = got_a.pop_front(); gb = got_b.pop_front(); s = stamp.pop_front();
         ea = exp_a.pop_front(); eb = exp_b.pop_front();
         if ({ga, gb} !== {ea, eb} || s != k + 15) begin
            miscompares++;
            $display("FAIL ignore_result got=%h/%h@%0d exp=%h/%h@%0d", ga, gb, s, ea, eb, k + 15);
         end
      end
      repeat (20) @(negedge clk);
      vectors++;
      if (got_a.size() != 0) begin
         miscompares++;
         $display("FAIL ignore_extra got=%0d extra results exp=0", got_a.size());
      end
   endtask

   task automatic test_back_to_back;
      int k, s1, s2;
      bit ok;
      logic [20:0] ga, gb, ea, eb;
      @(posedge clk);
      #1;
      start = 1'b1;
      bin   = BIN_W'(1357);
      exp_a.push_back(exp_word(1357, 1'b1));
      exp_b.push_back(exp_word(1357, 1'b0));
      @(posedge clk);
      #1;
      k   = cyc;
      bin = BIN_W'(56);
      exp_a.push_back(exp_word(56, 1'b1));
      exp_b.push_back(exp_word(56, 1'b0));
      repeat (16) @(posedge clk);
      #1;
      start = 1'b0;
      s1 = -1;
      for (int j = 0; j < 2; j++) begin
         wait_done(ok);
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("FAIL b2b_%0d timeout", j);
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
         end else begin
            ga = got_a.pop_front(); gb = got_b.pop_front(); s2 = stamp.pop_front();
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            if ({ga, gb} !== {ea, eb}) begin
               miscompares++;
               $display("FAIL b2b_%0d got=%h/%h exp=%h/%h", j, ga, gb, ea, eb);
            end
            vectors++;
            if (s2 != k + 15 + 16 * j) begin
               miscompares++;
               $display("FAIL b2b_timing_%0d got=%0d exp=%0d", j, s2, k + 15 + 16 * j);
            end
            s1 = s2;
         end
      end
   endtask

   task automatic test_reset_abort;
      int vals1[4] = '{1234, 0, 0, 0};
      int vals2[4] = '{42, 0, 0, 0};
      int k;
      run_table("pre_abort", vals1, 1);
      issue(8888, 1'b0, k);
      repeat (7) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if ({busy_a, done_a, ovf_a, a3, a2, a1, a0, busy_b, done_b, ovf_b, b3, b2, b1, b0} !==
          {3'b000, 5'h1F, 5'h1F, 5'h1F, 5'h00, 3'b000, 5'h1F, 5'h1F, 5'h1F, 5'h00}) begin
         miscompares++;
         $display("FAIL abort_outputs got=%b%b%b %h %h %h %h / %b%b%b %h %h %h %h", busy_a, done_a,
                  ovf_a, a3, a2, a1, a0, busy_b, done_b, ovf_b, b3, b2, b1, b0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (25) @(negedge clk);
      vectors++;
      if (got_a.size() != 0 || got_b.size() != 0) begin
         miscompares++;
         $display("FAIL abort_no_done got=%0d/%0d results exp=0", got_a.size(), got_b.size());
         got_a.delete(); got_b.delete(); stamp.delete();
      end
      run_table("post_abort", vals2, 1);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_basic();
      test_blanking();
      test_saturate();
      test_ignore_busy();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
